// File: rtl/online_pkg.sv
// Shared definitions for the online arithmetic datapath: signed-digit
// encodings (common with the multiplier) and the converter FSM state type.
package online_pkg;

    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } conv_state_t;

endpackage

// File: rtl/otfc_step.sv
// One step of on-the-fly conversion: appends a radix-2 signed digit to the
// Q/QM register pair, keeping QM == Q - 1 so no carry propagation is needed.
module otfc_step
    import online_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] qm,
    input  logic [1:0]       digit,
    output logic [WIDTH-1:0] next_q,
    output logic [WIDTH-1:0] next_qm
);

    always_comb begin
        // NOTE: both outputs get a value before the case so every path assigns them and no latch is inferred.
        next_q  = {q[WIDTH-2:0], 1'b0};
        next_qm = {qm[WIDTH-2:0], 1'b1};
        case (digit)
            DIG_POS: begin
                next_q  = {q[WIDTH-2:0], 1'b1};
                next_qm = {q[WIDTH-2:0], 1'b0};
            end
            DIG_NEG: begin
                next_q  = {qm[WIDTH-2:0], 1'b1};
                next_qm = {qm[WIDTH-2:0], 1'b0};
            end
            default: ;  // 2'b00 and the unused 2'b11 both mean zero
        endcase
    end

endmodule

// File: rtl/online_result_converter.sv
// Collects N_DIGITS signed digits MSD-first, converts them on the fly and
// presents the two's-complement word on a valid/ready output.
module online_result_converter
    import online_pkg::*;
#(
    parameter int N_DIGITS = 16
) (
    input  logic                clk,
    input  logic                asyn_reset_n,
    input  logic [1:0]          digit_in,
    input  logic                digit_vld,
    output logic                digit_rdy,
    output logic [N_DIGITS:0]   result,
    output logic                result_vld,
    input  logic                result_rdy
);

    localparam int WIDTH = N_DIGITS + 1;
    localparam int CW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_DIGITS - 1);

    conv_state_t      state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q, qm;
    logic [WIDTH-1:0] next_q, next_qm;
    logic             digit_hs, result_hs, last_digit;

    assign digit_rdy  = (state == ACCUM);
    assign result_vld = (state == HOLD);
    assign digit_hs   = digit_vld & digit_rdy;
    assign result_hs  = result_vld & result_rdy;
    assign last_digit = digit_hs && (cnt == LAST_CNT);

    otfc_step #(.WIDTH(WIDTH)) u_step (
        .q       (q),
        .qm      (qm),
        .digit   (digit_in),
        .next_q  (next_q),
        .next_qm (next_qm)
    );

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state <= ACCUM;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (last_digit) next_state = HOLD;
            HOLD:    if (result_hs)  next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    // The final step loads result directly from next_q while Q/QM restart for
    // the next frame, so the word is valid one cycle after the last digit.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            cnt    <= '0;
            q      <= '0;
            qm     <= '1;
            result <= '0;
        end else if (digit_hs) begin
            if (last_digit) begin
                cnt    <= '0;
                q      <= '0;
                qm     <= '1;
                result <= next_q;
            end else begin
                cnt <= cnt + CW'(1);
                q   <= next_q;
                qm  <= next_qm;
            end
        end
    end

endmodule

// File: doc/online_result_converter.md
Name: online_result_converter

Overview:
- Downstream stage of the online (MSD-first) multiplier.
- Consumes the multiplier's serial signed-digit product stream, one 2-bit radix-2 digit per handshake.
- Performs on-the-fly conversion (Q/QM registers) into a conventional two's-complement word.
- Presents the word on a valid/ready output, so the following Newton-iteration logic never handles redundant digits.

Parameters:
- N_DIGITS, 16, digits per frame; the result width is N_DIGITS+1.

Ports:
- clk  input  1  rising-edge clock.
- asyn_reset_n  input  1  reset, asynchronous, active-low; clears all state.
- digit_in  input  2  signed digit {plus, minus}: 2'b10 = +1, 2'b01 = -1, 2'b00 and 2'b11 = 0.
- digit_vld  input  1  digit_in valid.
- digit_rdy  output  1  converter accepts a digit this cycle.
- result  output  N_DIGITS+1  two's-complement value, integer units of 2^-N_DIGITS (sign bit plus N_DIGITS fraction bits).
- result_vld  output  1  result valid.
- result_rdy  input  1  consumer accepts result.

Behaviour:
- Clock and reset: one clock domain (clk). asyn_reset_n is asynchronous and active-low.
- Reset values: state=ACCUM, cnt=0, Q=0, QM=all ones (-1), result=0, result_vld=0, digit_rdy=1.
- Handshakes:
  - Digit handshake = digit_vld & digit_rdy.
  - Result handshake = result_vld & result_rdy.
  - digit_rdy = (state==ACCUM), driven directly from the state register; there is no combinational path from result_rdy.
- FSM:
  - ACCUM: on each digit handshake, update Q/QM and increment cnt. If cnt==N_DIGITS-1 at that handshake:
    - load the next-Q value into result;
    - set result_vld=1 on the following edge, so latency is 1 cycle after the last digit handshake;
    - clear cnt, Q=0, QM=-1;
    - go to HOLD.
  - HOLD: digit_rdy=0, and result and result_vld are stable. On a result handshake, result_vld=0 and go to ACCUM. result keeps its last value; the bench must not check it while result_vld=0.
- On-the-fly update, with {X,b} meaning X shifted left one place with b appended, truncated to N_DIGITS+1 bits:
  - d=+1: Q<={Q,1}, QM<={Q,0}.
  - d=0: Q<={Q,0}, QM<={QM,1}.
  - d=-1: Q<={QM,1}, QM<={QM,0}.
  - Invariant after every step: QM==Q-1.
  - Final Q = sum d_i*2^(N_DIGITS-i), range ±(2^N_DIGITS-1); overflow cannot occur.
- digit_vld low in ACCUM: hold all state; gaps of any length are legal. digit_in is ignored without a handshake.
- digit_in=2'b11 is converted as 0; no error is flagged.
- Throughput: at best one result per N_DIGITS+1 cycles. Frames are contiguous: the first digit after a result handshake starts a new frame.
- Reset mid-frame or in HOLD: the partial frame or pending result is discarded and all values return to reset values immediately.
- No frame-start signal: frame alignment is purely by digit count from reset.

Decomposition:
- Shared package online_pkg:
  - digit encodings DIG_POS=2'b10, DIG_NEG=2'b01, DIG_ZERO=2'b00;
  - FSM state type {ACCUM, HOLD};
  - these encodings are shared with the multiplier.
- One natural sub-module: otfc_step, combinational. Inputs q, qm, digit; outputs next_q, next_qm; parameterised by width. It is reusable by the online divider's output stage.
- The top-level holds the FSM, the counter, Q/QM and the result registers.

Test Plan (N_DIGITS=4, result 5 bits):
- Digits +1,0,-1,+1 back-to-back with result_rdy=1 -> result=5'b00111 (7), result_vld high exactly 1 cycle after the 4th handshake; digit_rdy low that cycle.
- Digits -1,-1,-1,-1 -> 5'b10001 (-15). Digits +1,-1,-1,-1 -> 5'b00001 (1). Digits 0,0,0,0 and 11,11,11,11 -> 5'b00000.
- Backpressure: result_rdy=0 for 5 cycles after result_vld rises -> result and result_vld stable, digit_rdy=0 throughout; result_rdy=1 -> result_vld drops next edge, digit_rdy=1.
- digit_vld toggling with random gaps on frame +1,+1,0,-1 (value 11) -> result=5'b01011 regardless of gaps; digit_in garbage during gaps ignored.
- asyn_reset_n pulsed low asynchronously after 2 digits of a frame -> outputs return to reset values at once; next 4 digits -1,0,0,0 -> 5'b11000 (-8).
- Two frames back-to-back (7, then -15) with result_rdy=1 -> two results in order, 5 cycles apart minimum; second frame unaffected by the first (Q/QM reinitialised).
